// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   start        operation request, accepted only while ready=1
//   dividend     n-bit unsigned dividend, captured on an accepted start
//   divisor      n-bit unsigned divisor, captured on an accepted start
//   ready        1 in IDLE and DONE (a start is accepted)
//   busy         1 while iterating (RUN)
//   done         one-cycle pulse when quotient/remainder become valid
//   quotient     result, held until the next result is loaded
//   remainder    result, held until the next result is loaded
//   div_by_zero  1 with the results of a divide by zero
module seq_div #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [n:0]      a_reg;    // partial remainder
  logic [n-1:0]    q_reg;    // dividend shifting out, quotient shifting in
  logic [n-1:0]    m_reg;    // divisor
  logic [CW-1:0]   cnt_reg;  // iterations left

  // One restoring step: S = {A, next dividend bit}, trial D = S - M.
  logic [n:0]   s_val;
  logic [n:0]   m_ext;
  logic [n:0]   d_val;
  logic [n+1:0] borrow;
  logic         bout;
  logic [n:0]   a_step;
  logic [n-1:0] q_step;

  assign s_val     = {a_reg[n-1:0], q_reg[n-1]};
  assign m_ext     = {1'b0, m_reg};
  assign borrow[0] = 1'b0;

  // Ripple-borrow subtractor, one full-subtractor cell per bit.
  genvar gi;
  generate
    for (gi = 0; gi <= n; gi++) begin : g_sub
      assign d_val[gi]    = s_val[gi] ^ m_ext[gi] ^ borrow[gi];
      assign borrow[gi+1] = (~s_val[gi] & m_ext[gi]) |
                            (~(s_val[gi] ^ m_ext[gi]) & borrow[gi]);
    end
  endgenerate

  // A borrow out means S < M: keep S (restore) and shift in a 0.
  assign bout   = borrow[n+1];
  assign a_step = bout ? s_val : d_val;
  assign q_step = {q_reg[n-2:0], ~bout};

  // After every step A < M, so the top bit of A never carries information.
  logic unused_a_msb;
  assign unused_a_msb = a_reg[n];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      cnt_reg     <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              // No iteration: report all-ones quotient right away.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state   <= RUN;
              ready   <= 1'b0;
              busy    <= 1'b1;
              a_reg   <= '0;
              q_reg   <= dividend;
              m_reg   <= divisor;
              cnt_reg <= CW'(n);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg   <= a_step;
          q_reg   <= q_step;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            // Last step: publish this step's values directly.
            state       <= DONE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_step;
            remainder   <= a_step[n-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // n = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0, dvs8 = '0;
  logic       rdy8, bsy8, dn8, dz8;
  logic [7:0] q8, r8;

  // n = 32 instance
  logic        start32 = 1'b0;
  logic [31:0] dvd32 = '0, dvs32 = '0;
  logic        rdy32, bsy32, dn32, dz32;
  logic [31:0] q32, r32;

  seq_div #(.n(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8)
  );

  seq_div #(.n(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .dividend(dvd32), .divisor(dvs32),
    .ready(rdy32), .busy(bsy32), .done(dn32), .quotient(q32), .remainder(r32),
    .div_by_zero(dz32)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one n=8 op from a negedge; returns at the negedge where done is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bcnt);
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1; bcnt = 0;
    while (!dn8 && lat < 40) begin
      if (bsy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    $display("n8  op %0d/%0d -> q=%0d r=%0d dz=%0b latency=%0d busy_cycles=%0d",
             a, b, q8, r8, dz8, lat, bcnt);
  endtask

  task automatic check8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int lat, bcnt;
    op8(a, b, lat, bcnt);
    check("n8 done", 64'(dn8), 64'(1));
    check("n8 latency", 64'(lat), (b == 0) ? 64'd1 : 64'd9);
    check("n8 busy cycles", 64'(bcnt), (b == 0) ? 64'd0 : 64'd8);
    check("n8 quotient", 64'(q8), 64'(eq));
    check("n8 remainder", 64'(r8), 64'(er));
    check("n8 div_by_zero", 64'(dz8), 64'(edz));
    check("n8 ready in done", 64'(rdy8), 64'(1));
  endtask

  task automatic check32(input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] eq, er;
    if (b == 0) begin eq = '1; er = a; end
    else begin eq = a / b; er = a % b; end
    start32 = 1'b1; dvd32 = a; dvs32 = b;
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (!dn32 && lat < 60) begin @(negedge clk); lat++; end
    $display("n32 op 0x%0h/0x%0h -> q=0x%0h r=0x%0h dz=%0b latency=%0d",
             a, b, q32, r32, dz32, lat);
    check("n32 latency", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
    check("n32 quotient", 64'(q32), 64'(eq));
    check("n32 remainder", 64'(r32), 64'(er));
    check("n32 div_by_zero", 64'(dz32), 64'(b == 0));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lat, bcnt, pulses, t;
    logic [7:0] ra, rb;
    logic [31:0] xa, xb;

    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    tbl[1] = '{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1};
    tbl[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[5] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
    tbl[6] = '{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1};

    // Reset state
    #12;
    check("reset ready", 64'(rdy8), 64'(1));
    check("reset busy", 64'(bsy8), 64'(0));
    check("reset done", 64'(dn8), 64'(0));
    check("reset quotient", 64'(q8), 64'(0));
    check("reset remainder", 64'(r8), 64'(0));
    check("reset div_by_zero", 64'(dz8), 64'(0));
    check("reset n32 ready", 64'(rdy32), 64'(1));
    check("reset n32 quotient", 64'(q32), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++)
      check8(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    // done must last exactly one cycle when no new start follows
    @(negedge clk);
    check("done single pulse", 64'(dn8), 64'(0));
    check("back to idle ready", 64'(rdy8), 64'(1));

    // Start while busy is ignored; old result stays visible during RUN
    check8(8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy in run", 64'(bsy8), 64'(1));
    check("ready low in run", 64'(rdy8), 64'(0));
    check("result held in run", 64'(q8), 64'(22));
    start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    t = 0;
    while (!dn8 && t < 40) begin @(negedge clk); t++; end
    $display("n8  op 100/7 with ignored start -> q=%0d r=%0d", q8, r8);
    check("ignored-start done", 64'(dn8), 64'(1));
    check("ignored-start quotient", 64'(q8), 64'(14));
    check("ignored-start remainder", 64'(r8), 64'(2));
    // Back-to-back start in the DONE cycle
    check8(8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    // and another one straight after, through the divide-by-zero path
    check8(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
    check8(8'd77, 8'd10, 8'd7, 8'd7, 1'b0);

    // Asynchronous reset in the middle of an op
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset busy", 64'(bsy8), 64'(0));
    check("mid-reset ready", 64'(rdy8), 64'(1));
    check("mid-reset quotient", 64'(q8), 64'(0));
    check("mid-reset remainder", 64'(r8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (dn8) pulses++;
    end
    check("no done after reset", 64'(pulses), 64'(0));
    check8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Randomized n=8 ops against arithmetic model
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      @(negedge clk);
      if (rb == 0) check8(ra, rb, 8'hFF, ra, 1'b1);
      else         check8(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    // n = 32
    @(negedge clk);
    check32(32'hFFFF_FFFF, 32'h0001_0000);
    for (int i = 0; i < 12; i++) begin
      xa = $urandom;
      xb = $urandom >> $urandom_range(0, 31);
      if (i == 5) xb = 32'd0;
      @(negedge clk);
      check32(xa, xb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
